// File: rtl/layer_window_reader.sv
// layer_window_reader
// Sweeps a square, row-major feature map as KxK windows with stride 1 and no
// padding. Each window is read from the layer memory through its shared
// two-lane read port and captured across all channels. The assembled window
// is then handed to the next convolution engine together with its linear
// output-pixel address.
module layer_window_reader #(
   parameter int W       = 14,
   parameter int K       = 3,
   parameter int IC_MAX  = 7,
   parameter int ADDR_W  = 10,
   parameter int OADDR_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          load,
   output logic [ADDR_W-1:0]             addr1,
   output logic [ADDR_W-1:0]             addr2,
   input  logic [(IC_MAX+1)*16-1:0]      mem_data,
   output logic [(IC_MAX+1)*K*K*8-1:0]   win_data,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [OADDR_W-1:0]            out_addr,
   output logic                          busy,
   output logic                          done
);

   localparam int NCH  = IC_MAX + 1;
   localparam int KK   = K * K;
   localparam int NP   = (KK + 1) / 2;
   localparam int OW   = W - K + 1;
   localparam int J_W  = $clog2(NP + 1);
   localparam int RC_W = $clog2(W) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAST,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [J_W-1:0]        r_j;
   logic [J_W-1:0]        r_capJ;
   logic                  r_capValid;
   logic [RC_W-1:0]       r_row;
   logic [RC_W-1:0]       r_col;
   logic                  r_load;
   logic [ADDR_W-1:0]     r_addr1;
   logic [ADDR_W-1:0]     r_addr2;
   logic [NCH*KK*8-1:0]   r_win;
   logic                  r_valid;
   logic [OADDR_W-1:0]    r_outAddr;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_lastCol;
   logic                  w_lastWin;
   logic [RC_W-1:0]       w_nextRow;
   logic [RC_W-1:0]       w_nextCol;

   // Map address of window pixel k (row-major inside the window).
   function automatic logic [ADDR_W-1:0] pixAddr(input int row, input int col, input int k);
      return ADDR_W'((row + k / K) * W + col + (k % K));
   endfunction

   // Address driven on one lane for read pair j; with an odd pixel count the
   // last pair repeats lane 0 on lane 1 and that lane's data is dropped.
   function automatic logic [ADDR_W-1:0] laneAddr(input int row, input int col,
                                                  input int j, input int lane);
      int k;
      k = 2 * j + lane;
      if (k >= KK) k = 2 * j;
      return pixAddr(row, col, k);
   endfunction

   // Position of the window that follows the current one in raster order.
   always_comb begin
      w_lastCol = (r_col == RC_W'(W - K));
      w_lastWin = w_lastCol && (r_row == RC_W'(W - K));
      w_nextRow = r_row;
      w_nextCol = r_col + 1'b1;
      if (w_lastCol) begin
         w_nextRow = r_row + 1'b1;
         w_nextCol = '0;
      end
   end

   // Scan controller: issues read pairs, presents windows, walks the map.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_j       <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_load    <= 1'b0;
         r_addr1   <= '0;
         r_addr2   <= '0;
         r_valid   <= 1'b0;
         r_outAddr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= S_FETCH;
                  r_busy  <= 1'b1;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_j     <= '0;
                  r_load  <= 1'b1;
                  r_addr1 <= laneAddr(0, 0, 0, 0);
                  r_addr2 <= laneAddr(0, 0, 0, 1);
               end
            end
            S_FETCH: begin
               r_j <= r_j + 1'b1;
               if (r_j == J_W'(NP - 1)) begin
                  r_state <= S_LAST;
                  r_load  <= 1'b0;
               end else begin
                  r_addr1 <= laneAddr(int'(r_row), int'(r_col), int'(r_j) + 1, 0);
                  r_addr2 <= laneAddr(int'(r_row), int'(r_col), int'(r_j) + 1, 1);
               end
            end
            S_LAST: begin
               r_state   <= S_PRESENT;
               r_valid   <= 1'b1;
               r_outAddr <= OADDR_W'(int'(r_row) * OW + int'(r_col));
            end
            S_PRESENT: begin
               if (win_ready) begin
                  r_valid <= 1'b0;
                  if (w_lastWin) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_row   <= w_nextRow;
                     r_col   <= w_nextCol;
                     r_j     <= '0;
                     r_load  <= 1'b1;
                     r_addr1 <= laneAddr(int'(w_nextRow), int'(w_nextCol), 0, 0);
                     r_addr2 <= laneAddr(int'(w_nextRow), int'(w_nextCol), 0, 1);
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Capture pipeline: the pair issued on one edge returns data that is
   // written into its window slots on the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_capValid <= 1'b0;
         r_capJ     <= '0;
         r_win      <= '0;
      end else begin
         r_capValid <= (r_state == S_FETCH);
         if (r_state == S_FETCH) r_capJ <= r_j;
         if (r_capValid && (r_state == S_FETCH || r_state == S_LAST)) begin
            for (int p = 0; p < NP; p++) begin
               if (r_capJ == J_W'(p)) begin
                  for (int ch = 0; ch < NCH; ch++) begin
                     r_win[(ch*KK + ((2*p+1 < KK) ? 2*p+1 : 2*p))*8 +: 8] <= mem_data[ch*16+8 +: 8];
                     r_win[(ch*KK + 2*p)*8 +: 8] <= mem_data[ch*16 +: 8];
                  end
               end
            end
         end
      end
   end

   assign load      = r_load;
   assign addr1     = r_addr1;
   assign addr2     = r_addr2;
   assign win_data  = r_win;
   assign win_valid = r_valid;
   assign out_addr  = r_outAddr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: doc/layer_window_reader.md
Name: layer_window_reader

Overview:
- Read-side counterpart of the per-channel layer memory: drives that memory's shared `load`/`addr1`/`addr2` read port and consumes its two read data lanes per channel.
- Scans the stored feature map as a sliding KxK window (stride 1, no padding) and assembles each window across all input channels.
- Presents each assembled window to the next convolution engine through a valid/ready handshake.
- Also outputs the linear output-pixel address, which the next layer uses as its store address.

Parameters:
- W, 14, stored feature-map width and height (square map, row-major, address = row*W + col).
- K, 3, window size; K*K <= 2*(W*W) and K <= W.
- IC_MAX, 7, highest input-channel index; channel count is IC_MAX+1.
- ADDR_W, 10, width of read addresses; must hold W*W-1.
- OADDR_W, 8, width of `out_addr`; must hold (W-K+1)^2-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a full-map scan; sampled only in IDLE.
- load  out  1  read enable to layer memory.
- addr1  out  ADDR_W  read address, lane 0.
- addr2  out  ADDR_W  read address, lane 1.
- mem_data  in  (IC_MAX+1)*16  read data; channel i lane0 = [i*16+7:i*16], lane1 = [i*16+15:i*16+8]; signed 8-bit; valid one cycle after the address edge.
- win_data  out  (IC_MAX+1)*K*K*8  assembled window; channel i, pixel k (row-major ky*K+kx) at bits [(i*K*K+k)*8 +: 8].
- win_valid  out  1  `win_data`/`out_addr` valid.
- win_ready  in  1  consumer accepts the window.
- out_addr  out  OADDR_W  r*(W-K+1)+c for the current window.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset values: state IDLE; all outputs 0; window registers 0; r = c = 0; pair index j = 0.
- NP = ceil(K*K/2) read pairs per window. Pair j reads pixel 2j on lane 0 and pixel 2j+1 on lane 1.
- Odd K*K: in the last pair, addr2 equals addr1 and the lane-1 data is discarded.
- Pixel address for window pixel k = (r + k/K)*W + (c + k%K).
- States:
  - IDLE: start=1 moves to FETCH with j = 0, r = c = 0.
  - FETCH: load=1; addresses are those of pair j. Each edge increments j. After the edge that issues pair NP-1, go to LAST.
  - LAST: load=0; captures the final pair, sets win_valid=1, then goes to PRESENT.
  - PRESENT: hold win_data, out_addr and win_valid until win_valid&&win_ready at an edge. Then:
    - Last window (r == c == W-K): go to DONE.
    - Otherwise: c advances, wrapping to 0 with r+1 when c == W-K; j = 0; go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- Capture timing: data for pair j is captured on the edge after the edge that issued it. The capture pipeline runs in FETCH and LAST.
- Latency: win_valid rises NP+1 edges after the start-sampling edge (6 for K=3). Each subsequent window also takes NP+1 edges after acceptance.
- win_ready asserted early (before win_valid) has no effect. win_valid never drops without acceptance.
- start while busy is ignored. start in the same cycle done is high is ignored; a new scan needs start in IDLE.
- load=0 in all states except FETCH. addr1/addr2 hold their last values when idle.
- No arithmetic on data; values pass through unchanged and signed.
- Reset mid-scan: immediate return to reset values; a partial window is never presented.

Test Plan:
- Set W=4, K=3, IC_MAX=1. Memory model: ch0 pixel = addr, ch1 pixel = addr+64, one-cycle read latency.
  - Pulse start, win_ready=1 -> load high 5 cycles; pairs (0,1),(2,4),(5,6),(8,9),(10,10); win_valid at edge 6; ch0 window = 0,1,2,4,5,6,8,9,10; ch1 = 64..74 pattern; out_addr=0.
  - Full scan with win_ready=1 -> 4 windows, out_addr 0,1,2,3; window 3 ch0 = 5,6,7,9,10,11,13,14,15; done pulses once; busy then falls.
  - Hold win_ready=0 for 10 cycles on window 1 -> win_valid and win_data stable, load=0, no address change; releasing accepts exactly once.
- Memory returns negative values (0x80, 0xFF) -> win_data carries them bit-exact.
- Assert start during FETCH and PRESENT -> no restart; window sequence unchanged.
- Assert rst during FETCH of window 2 -> all outputs 0 immediately; a new start rescans from out_addr=0.
